// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side handshake bundle around mem_port_arbiter.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [31:0]   i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_done;
  logic [31:0]   d_rdata;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_gnt;
  logic          m_rvalid;
  logic [31:0]   m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  m_gnt, m_rvalid, m_rdata,
    output i_done, i_rdata, d_done, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
    output m_gnt, m_rvalid, m_rdata,
    input  i_done, i_rdata, d_done, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding fetch/exec arbiter for the one memory port; MEM_ARB_RR_EN selects round-robin over data-first priority.
// Latency 3 cycles request-to-done (4 per transaction); requesters hold until done, memory stalls via m_gnt, WAIT timeout is fatal.
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_ERROR
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = data, 0 = fetch
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          pick_data;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;              // last owner, 1 = data

  // The requester that did not own the previous transaction wins a tie.
  assign pick_data = bus.d_req & (~bus.i_req | ~last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick_data = bus.d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d = S_ISSUE;
          owner_d = pick_data;
          if (pick_data) begin
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            wstrb_d = bus.d_we ? bus.d_wstrb : 4'b0000;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.i_addr;
            wdata_d = '0;
            wstrb_d = 4'b0000;
          end
        end
      end
      S_ISSUE: begin
        if (bus.m_gnt) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.m_rvalid) begin
          state_d = S_RESP;
          if (owner_q) begin
            d_rdata_d = bus.m_rdata;
          end else begin
            i_rdata_d = bus.m_rdata;
          end
`ifdef MEM_ARB_RR_EN
          last_d = owner_q;
`endif
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // Done is visible for this one cycle; IDLE follows so a stale request is never re-granted.
      S_RESP:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.m_req  = (state_q == S_ISSUE);
    bus.i_done = (state_q == S_RESP) && !owner_q;
    bus.d_done = (state_q == S_RESP) && owner_q;
    err        = (state_q == S_ERROR);
  end

  assign bus.m_we    = we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_wstrb = wstrb_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed stimulus for mem_port_arbiter with a done-pulse scoreboard and a simple memory responder.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int TO = 4;

  typedef struct {
    bit          owner;
    logic [31:0] rdata;
    int          at_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(.AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_done(input bit owner, input logic [31:0] d, input int c);
    exp_t e;
    e.owner  = owner;
    e.rdata  = d;
    e.at_cyc = c;
    sb.push_back(e);
  endtask

  // Memory responder: grants after gnt_dly ISSUE cycles, answers rv_dly cycles into WAIT.
  logic        gnt_drv = 1'b0;
  logic        rv_drv = 1'b0;
  logic        spur_rv = 1'b0;
  logic [31:0] rd_drv = '0;
  logic [31:0] mem_rdata = '0;
  int          gnt_dly = 0;
  int          rv_dly = 0;
  bit          resp_en = 1'b1;

  assign bus.m_gnt    = gnt_drv;
  assign bus.m_rvalid = rv_drv | spur_rv;
  assign bus.m_rdata  = spur_rv ? 32'hBAD0_BAD0 : rd_drv;

  initial begin : responder
    int gw;
    int rw;
    bit granted;
    gw = 0;
    rw = 0;
    granted = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      gnt_drv = 1'b0;
      rv_drv  = 1'b0;
      if (!rst_n) begin
        granted = 1'b0;
        gw = 0;
      end else if (granted) begin
        if (rw >= rv_dly) begin
          rv_drv  = resp_en;
          rd_drv  = mem_rdata;
          granted = 1'b0;
        end else begin
          rw++;
        end
      end else if (bus.m_req) begin
        if (gw >= gnt_dly) begin
          gnt_drv = 1'b1;
          granted = 1'b1;
          rw = 0;
          gw = 0;
        end else begin
          gw++;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.i_done || bus.d_done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", {62'd0, bus.i_done, bus.d_done}, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("done_onehot", 64'(bus.i_done & bus.d_done), 64'd0);
        check_eq("done_owner", 64'(bus.d_done), 64'(e.owner));
        check_eq("done_rdata", 64'(e.owner ? bus.d_rdata : bus.i_rdata), 64'(e.rdata));
        check_eq("done_cycle", 64'(cyc), 64'(e.at_cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit owner, input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (!(owner ? bus.d_done : bus.i_done) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL done_wait: no done from owner %0d within %0d cycles", owner, max);
    end
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_wstrb = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mreq", 64'(bus.m_req), 64'd0);
    check_eq("rst_we_strb", {59'd0, bus.m_we, bus.m_wstrb}, 64'd0);
    check_eq("rst_addr", 64'(bus.m_addr), 64'd0);
    check_eq("rst_wdata", 64'(bus.m_wdata), 64'd0);
    check_eq("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
    check_eq("rst_done_err", {61'd0, bus.i_done, bus.d_done, err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: fetch against zero-wait memory
    gnt_dly = 0; rv_dly = 0; mem_rdata = 32'h0010_0093;
    tick();
    n0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
    expect_done(1'b0, 32'h0010_0093, n0 + 3);
    @(negedge clk);
    check_eq("f_mreq_n", 64'(bus.m_req), 64'd0);
    @(negedge clk);
    check_eq("f_mreq_n1", 64'(bus.m_req), 64'd1);
    check_eq("f_addr", 64'(bus.m_addr), 64'h40);
    check_eq("f_we_strb", {59'd0, bus.m_we, bus.m_wstrb}, 64'd0);
    @(negedge clk);
    check_eq("f_mreq_n2", 64'(bus.m_req), 64'd0);
    wait_done(1'b0, 20);
    bus.i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("f_no_regrant", 64'(bus.m_req), 64'd0);

    // 2: store with 2 grant and 3 response wait states
    gnt_dly = 2; rv_dly = 3; mem_rdata = 32'h0000_0001;
    tick();
    n0 = cyc;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'b0011;
    expect_done(1'b1, 32'h0000_0001, n0 + 8);
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_eq("s_issue_mreq", 64'(bus.m_req), 64'd1);
      check_eq("s_issue_addr", 64'(bus.m_addr), 64'h100);
      check_eq("s_issue_wdata", 64'(bus.m_wdata), 64'hDEAD_BEEF);
      check_eq("s_issue_we_strb", {59'd0, bus.m_we, bus.m_wstrb}, 64'h13);
    end
    @(negedge clk);
    check_eq("s_wait_mreq", 64'(bus.m_req), 64'd0);
    wait_done(1'b1, 20);
    bus.d_req = 1'b0; bus.d_we = 1'b0;

    // 6: spurious m_rvalid in IDLE and in ISSUE
    gnt_dly = 2; rv_dly = 0; mem_rdata = 32'h0000_0013;
    tick();
    spur_rv = 1'b1;
    tick();
    spur_rv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("sp_idle_mreq", 64'(bus.m_req), 64'd0);
    check_eq("sp_idle_drdata", 64'(bus.d_rdata), 64'h1);
    tick();
    n0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0044;
    expect_done(1'b0, 32'h0000_0013, n0 + 5);
    tick();
    spur_rv = 1'b1;
    tick();
    spur_rv = 1'b0;
    @(negedge clk);
    check_eq("sp_issue_mreq", 64'(bus.m_req), 64'd1);
    wait_done(1'b0, 20);
    bus.i_req = 1'b0;

    // 3: simultaneous requests held through four transactions
    gnt_dly = 0; rv_dly = 0; mem_rdata = 32'h1234_5678;
    tick();
    n0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h80;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_wstrb = 4'b1111;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      expect_done((k % 2) == 0, 32'h1234_5678, n0 + 3 + 4 * k);
`else
      expect_done(1'b1, 32'h1234_5678, n0 + 3 + 4 * k);
`endif
    end
    @(negedge clk);
    @(negedge clk);
    check_eq("both_first_addr", 64'(bus.m_addr), 64'h200);
    check_eq("load_wstrb", 64'(bus.m_wstrb), 64'd0);
    repeat (15) tick();
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_wstrb = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check_eq("both_end_mreq", 64'(bus.m_req), 64'd0);

    // 4: timeout after TO WAIT cycles, then sticky ERROR
    gnt_dly = 0; rv_dly = 0; resp_en = 1'b0;
    tick();
    n0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h48;
    repeat (6) @(negedge clk);
    check_eq("to_err_before", 64'(err), 64'd0);
    @(negedge clk);
    check_eq("to_err_after", 64'(err), 64'd1);
    check_eq("to_err_mreq", 64'(bus.m_req), 64'd0);
    tick();
    bus.i_req = 1'b0;
    tick();
    bus.i_req = 1'b1; bus.i_addr = 32'h4C;
    resp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("to_ignore_req", 64'(bus.m_req), 64'd0);
    end
    tick();
    spur_rv = 1'b1;
    tick();
    spur_rv = 1'b0;
    @(negedge clk);
    check_eq("to_err_sticky", 64'(err), 64'd1);
    bus.i_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("to_rst_err", {62'd0, err, bus.m_req}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 5: asynchronous reset during WAIT, then a fresh fetch
    gnt_dly = 0; rv_dly = 3; mem_rdata = 32'hFFFF_0000;
    tick();
    n0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h50;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_rst_outs", {60'd0, bus.m_req, bus.i_done, bus.d_done, err}, 64'd0);
    bus.i_req = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    check_eq("mr_rdata_lost", 64'(bus.i_rdata), 64'd0);
    rv_dly = 0; mem_rdata = 32'h0000_0297;
    tick();
    n0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h54;
    expect_done(1'b0, 32'h0000_0297, n0 + 3);
    wait_done(1'b0, 20);
    bus.i_req = 1'b0;

    repeat (4) tick();
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
